// File: rtl/regfile_ctrl_pkg.sv
// Shared types and defaults for the register-file access controller.
package regfile_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ctrl_state_t;

    localparam int unsigned RF_DATA_W   = 16;
    localparam int unsigned RF_ADDR_W   = 3;
    localparam int unsigned RF_NUM_REGS = 8;

    // Width of a requester index; never zero so a single requester still gets a 1-bit pointer.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts just after the last winner.
module rr_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [ptr_w(NUM_REQ)-1:0]   last_i,
    input  logic                        en_i,
    output logic [NUM_REQ-1:0]          gnt_o
);

    localparam int unsigned PtrW = ptr_w(NUM_REQ);

    logic             found;
    logic [PtrW-1:0]  idx;

    // Walk last+1 .. last+NUM_REQ (wrapping) and grant the first valid requester.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = PtrW'((32'(last_i) + k) % NUM_REQ);
            if (en_i && !found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Arbitrates requesters onto the register file's write/SR1 ports and sequences CLEAR.
module regfile_access_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_REGS = RF_NUM_REGS
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ-1:0]         req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    output logic [DATA_W-1:0]          rsp_rdata_o,
    input  logic                       clear_start_i,
    output logic                       busy_o,
    output logic                       rf_load_o,
    output logic [ADDR_W-1:0]          rf_dr_o,
    output logic [DATA_W-1:0]          rf_bus_o,
    output logic [ADDR_W-1:0]          rf_sr1_o,
    input  logic [DATA_W-1:0]          rf_sr1_data_i
);

    localparam int unsigned       PtrW     = ptr_w(NUM_REQ);
    localparam logic [PtrW-1:0]   LastInit = PtrW'(NUM_REQ - 1);
    localparam logic [ADDR_W-1:0] LastReg  = ADDR_W'(NUM_REGS - 1);

    ctrl_state_t          state_q;
    logic [ADDR_W-1:0]    cnt_q;
    logic [PtrW-1:0]      last_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [DATA_W-1:0]    rsp_rdata_q;

    logic                 arb_en;
    logic [NUM_REQ-1:0]   gnt;
    logic                 gnt_any;
    logic [PtrW-1:0]      gnt_idx;
    logic                 g_we;
    logic [ADDR_W-1:0]    g_addr;
    logic [DATA_W-1:0]    g_wdata;

    // clear_start beats any pending request; reset gating keeps ready low while held in reset.
    assign arb_en = rst_ni && (state_q == IDLE) && !clear_start_i;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i  (req_valid_i),
        .last_i (last_q),
        .en_i   (arb_en),
        .gnt_o  (gnt)
    );

    assign gnt_any     = |gnt;
    assign req_ready_o = gnt;
    assign busy_o      = (state_q == CLEAR);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

    // Select the granted requester's index and fields from the one-hot grant.
    always_comb begin
        gnt_idx = '0;
        g_we    = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = PtrW'(i);
                g_we    = req_we_i[i];
                g_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                g_wdata = req_wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Register-file port drive: CLEAR zero-fill, granted write, granted read, or all zero.
    always_comb begin
        rf_load_o = 1'b0;
        rf_dr_o   = '0;
        rf_bus_o  = '0;
        rf_sr1_o  = '0;
        if (state_q == CLEAR) begin
            rf_load_o = 1'b1;
            rf_dr_o   = cnt_q;
        end else if (gnt_any) begin
            if (g_we) begin
                rf_load_o = 1'b1;
                rf_dr_o   = g_addr;
                rf_bus_o  = g_wdata;
            end else begin
                rf_sr1_o  = g_addr;
            end
        end
    end

    // Control FSM, RR pointer, clear counter and registered read response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= LastInit;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (clear_start_i) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                    end else if (gnt_any) begin
                        last_q <= gnt_idx;
                        if (!g_we) begin
                            rsp_valid_q <= gnt;
                            rsp_rdata_q <= rf_sr1_data_i;
                        end
                    end
                end
                CLEAR: begin
                    if (cnt_q == LastReg) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Randomized self-checking bench for regfile_access_ctrl with a behavioural reference model.
module tb_regfile_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_rdata;
    logic        clear_start;
    logic        busy;
    logic        rf_load;
    logic [2:0]  rf_dr;
    logic [15:0] rf_bus;
    logic [2:0]  rf_sr1;
    logic [15:0] rf_sr1_data;

    int checks;
    int failures;

    // Register file environment (what the DUT actually drives).
    logic [15:0] rf_mem [8];
    // Reference model state.
    logic [15:0] ref_mem [8];
    int          exp_last;
    logic [1:0]  exp_rsp_valid;
    logic [15:0] exp_rsp_rdata;

    regfile_access_ctrl #(
        .NUM_REQ  (2),
        .DATA_W   (16),
        .ADDR_W   (3),
        .NUM_REGS (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_we_i      (req_we),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .req_ready_o   (req_ready),
        .rsp_valid_o   (rsp_valid),
        .rsp_rdata_o   (rsp_rdata),
        .clear_start_i (clear_start),
        .busy_o        (busy),
        .rf_load_o     (rf_load),
        .rf_dr_o       (rf_dr),
        .rf_bus_o      (rf_bus),
        .rf_sr1_o      (rf_sr1),
        .rf_sr1_data_i (rf_sr1_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_load) rf_mem[rf_dr] <= rf_bus;
    end
    assign rf_sr1_data = rf_mem[rf_sr1];

    // Round-robin rule: first valid requester after the last winner, wrapping.
    function automatic int exp_grant(input logic [1:0] v);
        for (int k = 1; k <= 2; k++) begin
            if (v[(exp_last + k) % 2]) return (exp_last + k) % 2;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exp_last      = 1;
        exp_rsp_valid = 2'b00;
        exp_rsp_rdata = 16'h0000;
    endtask

    // One IDLE cycle: check last response, drive a request pattern, check grant and rf ports.
    task automatic step(input logic [1:0] v, input logic [1:0] we, input logic [2:0] a0,
                        input logic [2:0] a1, input logic [15:0] d0, input logic [15:0] d1);
        int          gi;
        logic [1:0]  eg;
        logic [2:0]  ea;
        logic [15:0] ed;
        logic        el;
        logic [2:0]  edr;
        logic [15:0] ebus;
        logic [2:0]  esr1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== exp_rsp_valid) begin
            failures++;
            $display("FAIL rsp_valid: got %b expected %b", rsp_valid, exp_rsp_valid);
        end
        checks++;
        if (rsp_rdata !== exp_rsp_rdata) begin
            failures++;
            $display("FAIL rsp_rdata: got %h expected %h", rsp_rdata, exp_rsp_rdata);
        end
        req_valid   = v;
        req_we      = we;
        req_addr    = {a1, a0};
        req_wdata   = {d1, d0};
        clear_start = 1'b0;
        #1;
        gi   = exp_grant(v);
        eg   = (gi < 0) ? 2'b00 : ((gi == 0) ? 2'b01 : 2'b10);
        ea   = (gi == 1) ? a1 : a0;
        ed   = (gi == 1) ? d1 : d0;
        el   = 1'b0;
        edr  = 3'd0;
        ebus = 16'h0000;
        esr1 = 3'd0;
        if (gi >= 0) begin
            if (we[gi]) begin
                el   = 1'b1;
                edr  = ea;
                ebus = ed;
            end else begin
                esr1 = ea;
            end
        end
        checks++;
        if (req_ready !== eg) begin
            failures++;
            $display("FAIL req_ready: got %b expected %b (valid %b)", req_ready, eg, v);
        end
        checks++;
        if ({rf_load, rf_dr, rf_bus, rf_sr1} !== {el, edr, ebus, esr1}) begin
            failures++;
            $display("FAIL rf_ports: got load=%b dr=%0d bus=%h sr1=%0d expected load=%b dr=%0d bus=%h sr1=%0d",
                     rf_load, rf_dr, rf_bus, rf_sr1, el, edr, ebus, esr1);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_idle: got %b expected 0", busy);
        end
        exp_rsp_valid = 2'b00;
        if (gi >= 0) begin
            exp_last = gi;
            if (we[gi]) begin
                ref_mem[ea] = ed;
            end else begin
                exp_rsp_valid = eg;
                exp_rsp_rdata = ref_mem[ea];
            end
        end
    endtask

    task automatic step_random();
        step(2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom),
             16'($urandom), 16'($urandom));
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, busy, rf_load, rf_dr, rf_bus, rf_sr1} !== '0) begin
            failures++;
            $display("FAIL %s: got ready=%b rsp_v=%b rdata=%h busy=%b load=%b dr=%0d bus=%h sr1=%0d expected all 0",
                     tag, req_ready, rsp_valid, rsp_rdata, busy, rf_load, rf_dr, rf_bus, rf_sr1);
        end
    endtask

    // Zero-fill sequence; optionally re-pulse clear_start or assert reset at a given CLEAR cycle.
    task automatic do_clear(input int pulse_at, input int reset_at);
        @(negedge clk);
        checks++;
        if (rsp_valid !== exp_rsp_valid || rsp_rdata !== exp_rsp_rdata) begin
            failures++;
            $display("FAIL pre_clear_rsp: got %b/%h expected %b/%h",
                     rsp_valid, rsp_rdata, exp_rsp_valid, exp_rsp_rdata);
        end
        clear_start = 1'b1;
        req_valid   = 2'b01;
        req_we      = 2'b00;
        req_addr    = 6'o01;
        #1;
        checks++;
        if ({req_ready, rf_load, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL clear_start_no_grant: got ready=%b load=%b busy=%b expected 00/0/0",
                     req_ready, rf_load, busy);
        end
        exp_rsp_valid = 2'b00;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            clear_start = (c == pulse_at);
            if (c == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("reset_mid_clear");
                model_reset();
                @(negedge clk);
                req_valid   = 2'b00;
                clear_start = 1'b0;
                rst_n       = 1'b1;
                return;
            end
            #1;
            checks++;
            if ({busy, req_ready, rf_load, rf_dr, rf_bus, rsp_valid} !== {1'b1, 2'b00, 1'b1, 3'(c), 16'h0, 2'b00}) begin
                failures++;
                $display("FAIL clear_cycle%0d: got busy=%b ready=%b load=%b dr=%0d bus=%h rsp_v=%b expected 1/00/1/%0d/0000/00",
                         c, busy, req_ready, rf_load, rf_dr, rf_bus, rsp_valid, c);
            end
            ref_mem[c] = 16'h0000;
        end
        clear_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        req_valid   = 2'b11;
        req_we      = 2'b11;
        req_addr    = 6'o21;
        req_wdata   = 32'h1234_5678;
        clear_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_hold");
        model_reset();
        @(negedge clk);
        req_valid = 2'b00;
        rst_n     = 1'b1;
        step(2'b11, 2'($urandom), 3'($urandom), 3'($urandom), 16'($urandom), 16'($urandom));
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL first_grant: got %b expected 01", req_ready);
        end
    endtask

    task automatic test_reset_midop();
        repeat (6) step_random();
        step(2'b01, 2'b00, 3'($urandom), 3'd0, 16'h0, 16'h0);
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_we    = 2'b11;
        #1;
        check_all_zero("reset_async");
        model_reset();
        @(negedge clk);
        req_valid = 2'b00;
        rst_n     = 1'b1;
        step(2'b11, 2'b11, 3'($urandom), 3'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic test_alternate();
        logic [1:0] prev;
        prev = req_ready;
        for (int i = 0; i < 6; i++) begin
            step(2'b11, 2'($urandom), 3'($urandom), 3'($urandom), 16'($urandom), 16'($urandom));
            checks++;
            if (req_ready !== ~prev) begin
                failures++;
                $display("FAIL alternate%0d: got %b expected %b", i, req_ready, ~prev);
            end
            prev = req_ready;
        end
    endtask

    task automatic test_raw();
        step(2'b01, 2'b01, 3'd3, 3'd0, 16'hBEEF, 16'h0);
        step(2'b10, 2'b00, 3'd0, 3'd3, 16'h0, 16'h0);
        step(2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
        checks++;
        if (rf_mem[3] !== 16'hBEEF) begin
            failures++;
            $display("FAIL raw_regfile: got %h expected beef", rf_mem[3]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) step_random();
    endtask

    task automatic test_clear();
        do_clear(-1, -1);
        step(2'b01, 2'b00, 3'd1, 3'd0, 16'h0, 16'h0);
        for (int r = 0; r < 8; r++) step(2'b10, 2'b00, 3'd0, 3'(r), 16'h0, 16'h0);
        step(2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
    endtask

    task automatic test_clear_restart();
        repeat (10) step_random();
        do_clear(4, -1);
        step(2'b11, 2'b00, 3'($urandom), 3'($urandom), 16'h0, 16'h0);
        step(2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
    endtask

    task automatic test_reset_mid_clear();
        step(2'b01, 2'b01, 3'd5, 3'd0, 16'hA5C3, 16'h0);
        do_clear(-1, 3);
        for (int r = 0; r < 8; r++) step(2'b01, 2'b00, 3'(r), 3'd0, 16'h0, 16'h0);
        step(2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
        checks++;
        if (rf_mem[5] !== 16'hA5C3) begin
            failures++;
            $display("FAIL r5_kept: got %h expected a5c3", rf_mem[5]);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 8; i++) begin
            rf_mem[i]  = 16'($urandom);
            ref_mem[i] = rf_mem[i];
        end
        test_reset();
        test_alternate();
        test_raw();
        test_random();
        test_reset_midop();
        test_clear();
        test_clear_restart();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
